register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 17 +
 rtl/register_word.sv | 31 +++
 rtl/register_file.sv | 61 ++++++
 tb/tb_register_file.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
//   Shared sizing for the register file and its storage words.
//   DEF_DATA_W : default word width in bits.
//   DEF_ADDR_W : default address width in bits (2**DEF_ADDR_W registers).
//   regCount() : number of registers addressed by an address of a given width.
// -----------------------------------------------------------------------------
package register_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;

  function automatic int regCount(input int addrW);
    return 1 << addrW;
  endfunction

endpackage

// File: rtl/register_word.sv
// -----------------------------------------------------------------------------
// register_word
//   One DATA_W-bit storage word with load enable and asynchronous clear.
//   Ports:
//     clk   in   clock, loads on rising edge
//     clrN  in   asynchronous active-low clear to zero
//     load  in   load enable; when high, d is captured at the rising edge
//     d     in   DATA_W  data to load
//     q     out  DATA_W  stored word
// -----------------------------------------------------------------------------
module register_word
  import register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clrN,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge clrN) begin
    if (!clrN) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   2**ADDR_W x DATA_W register file with one write port and one
//   asynchronous (combinational) read port, usable in the same cycle.
//   There is no write-through bypass: a read of the address being written
//   shows the old contents until the clock edge.
//   Ports:
//     clk      in   clock, writes on rising edge
//     reset_n  in   asynchronous active-low reset, clears every register
//     wAddr    in   ADDR_W  write address
//     wData    in   DATA_W  write data
//     we       in   write enable, active-high
//     rAddr    in   ADDR_W  read address
//     rData    out  DATA_W  contents of the register at rAddr
// -----------------------------------------------------------------------------
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic              we,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [DATA_W-1:0] rData
);

  localparam int NUM_REGS = regCount(ADDR_W);

  logic [NUM_REGS-1:0] wSel;
  logic [DATA_W-1:0]   words [NUM_REGS];

  // One-hot write select; all zero when we is low so nothing can load.
  always_comb begin
    wSel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wSel[i] = we && (wAddr == ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gWord
    register_word #(
      .DATA_W(DATA_W)
    ) uWord (
      .clk (clk),
      .clrN(reset_n),
      .load(wSel[g]),
      .d   (wData),
      .q   (words[g])
    );
  end

  // Words clear asynchronously, so the mux alone returns zero during reset.
  always_comb begin
    rData = words[rAddr];
  end

endmodule

// File: tb/tb_register_file.sv
`timescale 1ns/1ps
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;
  logic          we;
  logic [AW-1:0] rAddr;
  logic [DW-1:0] rData;

  int total = 0;
  int bad   = 0;

  // Reference contents of the register file.
  logic [DW-1:0] model [NR];

  typedef struct {
    logic          vWe;
    logic [AW-1:0] vWAddr;
    logic [DW-1:0] vWData;
    logic [AW-1:0] vRAddr;
    logic [DW-1:0] vExp;
  } vec_t;

  vec_t vecs [12];

  register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .wAddr  (wAddr),
    .wData  (wData),
    .we     (we),
    .rAddr  (rAddr),
    .rData  (rData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive at negedge, let the rising edge happen, sample 1ns later.
  task automatic writeEdge(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    we = 1'b1; wAddr = a; wData = d;
    @(posedge clk);
    if (reset_n) model[a] = d;
    #1;
    we = 1'b0;
  endtask

  task automatic sweepModel(input string name);
    for (int i = 0; i < NR; i++) begin
      rAddr = AW'(i);
      #0.4;
      check(name, rData, model[i]);
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          w;

    vecs[0]  = '{1'b1, 3'd1, 32'hFF00FF00, 3'd1, 32'hFF00FF00};
    vecs[1]  = '{1'b1, 3'd2, 32'hFF00FF00, 3'd2, 32'hFF00FF00};
    vecs[2]  = '{1'b1, 3'd3, 32'h00FF00FF, 3'd3, 32'h00FF00FF};
    vecs[3]  = '{1'b0, 3'd0, 32'h00000000, 3'd1, 32'hFF00FF00};
    vecs[4]  = '{1'b0, 3'd0, 32'h00000000, 3'd2, 32'hFF00FF00};
    vecs[5]  = '{1'b0, 3'd3, 32'hDEADBEEF, 3'd3, 32'h00FF00FF};
    vecs[6]  = '{1'b0, 3'd3, 32'hDEADBEEF, 3'd3, 32'h00FF00FF};
    vecs[7]  = '{1'b0, 3'd3, 32'hDEADBEEF, 3'd3, 32'h00FF00FF};
    vecs[8]  = '{1'b1, 3'd7, 32'h12345678, 3'd7, 32'h12345678};
    vecs[9]  = '{1'b1, 3'd7, 32'h87654321, 3'd7, 32'h87654321};
    vecs[10] = '{1'b1, 3'd4, 32'hCAFEF00D, 3'd0, 32'h11111111};
    vecs[11] = '{1'b0, 3'd4, 32'h0BADC0DE, 3'd4, 32'hCAFEF00D};

    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state, and writes ignored while reset is held.
    reset_n = 1'b0; we = 1'b1; wAddr = '0; wData = 32'h55555555; rAddr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_addr0", rData, 32'h0);
    sweepModel("reset_sweep");

    // Release between edges; first write lands on the next edge.
    @(negedge clk);
    reset_n = 1'b1; we = 1'b0;
    writeEdge(3'd0, 32'h11111111);
    rAddr = 3'd0; #0.1;
    check("first_write", rData, 32'h11111111);

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      we = vecs[i].vWe; wAddr = vecs[i].vWAddr; wData = vecs[i].vWData; rAddr = vecs[i].vRAddr;
      @(posedge clk);
      if (vecs[i].vWe) model[vecs[i].vWAddr] = vecs[i].vWData;
      #1;
      check($sformatf("vec%0d", i), rData, vecs[i].vExp);
    end
    @(negedge clk); we = 1'b0;
    sweepModel("after_table");

    // Read-during-write on address 5: old value before edge, new after.
    @(negedge clk);
    rAddr = 3'd5; wAddr = 3'd5; we = 1'b1; wData = 32'hA5A5A5A5;
    #1;
    check("rdw_before", rData, 32'h0);
    @(posedge clk);
    model[5] = 32'hA5A5A5A5;
    #1;
    check("rdw_after", rData, 32'hA5A5A5A5);

    // Inputs that change between edges must have no effect.
    @(negedge clk);
    we = 1'b1; wAddr = 3'd6; wData = 32'hFFFFFFFF; rAddr = 3'd6;
    #2;
    we = 1'b0;
    @(posedge clk); #1;
    check("between_edges", rData, 32'h0);

    // Randomized traffic against the reference array.
    for (int n = 0; n < 400; n++) begin
      w  = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, NR - 1));
      wd = $urandom;
      ra = AW'($urandom_range(0, NR - 1));
      @(negedge clk);
      we = w; wAddr = wa; wData = wd; rAddr = ra;
      #1;
      check("rand_pre", rData, model[ra]);
      @(posedge clk);
      if (w) model[wa] = wd;
      #1;
      check("rand_post", rData, model[ra]);
    end
    @(negedge clk); we = 1'b0;

    // Fill with index * 0x01010101, then reset asynchronously mid-cycle.
    for (int i = 0; i < NR; i++) writeEdge(AW'(i), DW'(i) * 32'h01010101);
    sweepModel("fill");
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    #0.1;
    sweepModel("async_clear");

    // Write attempt under reset, then release mid-cycle and write.
    writeEdge(3'd2, 32'h77777777);
    rAddr = 3'd2; #0.1;
    check("write_in_reset", rData, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    writeEdge(3'd2, 32'h77777777);
    rAddr = 3'd2; #0.1;
    check("write_after_reset", rData, 32'h77777777);
    sweepModel("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
